gray_conv_scheduler: RTL and testbench
======================================

// Module: gray_conv_scheduler
// PURPOSE
// - Shares one 4-bit binary-to-Gray converter (binary2gray) among N_REQ requesters.
// - Each requester offers a 4-bit binary code with a valid/ready handshake.
// - A round-robin arbiter grants one requester per cycle.
// - The converted Gray code is registered with the requester ID. The result leaves on one valid/ready output port.
// - The block sits between the lab stimulus sources and the downstream display/capture logic.
// PARAMETERS
// - N_REQ  4   number of requesters, 2..8
// - ID_W   2   requester ID width, = clog2(N_REQ)
// - CNT_W  16  width of the completed-conversion counter
// PORTS
// - clk        in   1          rising-edge clock, single clock domain
// - rst        in   1          synchronous, active-high reset
// - req_valid  in   N_REQ      per-requester valid
// - req_bin    in   4*N_REQ    requester i code at [4*i+3:4*i]
// - req_ready  out  N_REQ      one-hot grant/accept, combinational
// - out_valid  out  1          result register holds valid data
// - out_ready  in   1          downstream accepts the result
// - out_gray   out  4          Gray code, = bin ^ (bin >> 1)
// - out_bin    out  4          original binary code, echoed
// - out_id     out  ID_W       index of the requester served
// - conv_cnt   out  CNT_W      count of accepted outputs, saturating
// BEHAVIOUR
// - Reset:
//   - Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
//   - While rst=1 at a clk edge, all registers load their reset values:
//     - out_valid=0, out_gray=0, out_bin=0, out_id=0.
//     - conv_cnt=0, rr_ptr=0.
//   - req_ready is 0 during reset.
//   - Reset mid-transaction discards any held result with no handshake.
// - Slot free:
//   - slot_free = !out_valid || out_ready.
//   - This is a 1-deep pipe: full throughput of 1 conversion/cycle when out_ready=1.
// - Arbitration (combinational):
//   - Search req_valid starting at rr_ptr, ascending with wrap N_REQ-1 -> 0.
//   - The first set bit is the winner w.
//   - req_ready[w] = slot_free && any(req_valid). All other req_ready bits are 0.
//   - req_ready never asserts for a requester whose valid is 0.
// - Accept edge (req_valid[w] && req_ready[w]):
//   - out_bin <= req_bin[w]; out_gray <= converter output; out_id <= w; out_valid <= 1.
//   - rr_ptr <= (w+1) mod N_REQ.
// - Latency: 1 cycle from accept to out_valid.
// - Drain edge:
//   - Drain = out_valid && out_ready with no new accept.
//   - out_valid <= 0. Data registers hold their last values.
// - Simultaneous drain and accept: new data replaces old, out_valid stays 1 (no bubble).
// - Stall: out_valid=1 && out_ready=0:
//   - All req_ready=0.
//   - Output registers stable.
//   - rr_ptr holds.
// - No requests: rr_ptr holds, no state change except drain.
// - conv_cnt:
//   - Increments on every out_valid && out_ready edge.
//   - Saturates at 2^CNT_W-1 and does not wrap.
// - Requesters must hold req_valid and req_bin stable until accepted. The block does not check this.
// STRUCTURE
// - Package gray_sched_pkg:
//   - localparam CODE_W=4.
//   - function rr_pick(valid, ptr) returning winner index.
//   - typedef of the result struct {bin, gray, id}.
// - One sub-module, binary2gray (4-bit combinational converter), instantiated once on the muxed req_bin[w].
// - Top holds the arbiter logic, rr_ptr, the result register and conv_cnt.
// TESTING
// - Single requester:
//   - Stimulus: req 1 sends 4'd10, out_ready=1.
//   - Response: next cycle out_valid=1, out_gray=4'b1111, out_bin=4'd10, out_id=1, conv_cnt=1.
// - All 4 valid continuously, out_ready=1:
//   - Grants in order 0,1,2,3,0,... one per cycle.
//   - No grant is skipped or repeated.
// - Backpressure:
//   - Stimulus: result 4'd15 pending, out_ready=0 for 5 cycles.
//   - Response: out_gray=4'b1000 held, req_ready=0, conv_cnt unchanged. On release, the next winner is accepted in the same cycle.
// - Exhaustive codes:
//   - Stimulus: codes 0..15 via requester 2.
//   - Response: out_gray matches b^(b>>1) for each, e.g. 7 -> 4'b0100, 12 -> 4'b1010.
// - Reset mid-stall:
//   - Stimulus: rst=1 for 1 cycle while out_valid=1.
//   - Response: next cycle out_valid=0, conv_cnt=0. The first grant afterwards goes to requester 0.
// - Saturation:
//   - Stimulus: CNT_W=4, 20 accepted outputs.
//   - Response: conv_cnt=15 and it stays at 15.

Source files
------------

// File: rtl/gray_sched_pkg.sv
// Shared definitions for the Gray-conversion scheduler: code width,
// requester limits, the registered result record and the round-robin pick.
package gray_sched_pkg;

  localparam int CODE_W   = 4;
  localparam int MAX_REQ  = 8;
  localparam int MAX_ID_W = 3;

  // Result record captured when a requester is accepted.
  typedef struct packed {
    logic [CODE_W-1:0]   bin;
    logic [CODE_W-1:0]   gray;
    logic [MAX_ID_W-1:0] id;
  } gray_result_t;

  // Round-robin search: first set bit of valid starting at ptr, ascending,
  // wrapping n_req-1 -> 0. Returns 0 when no bit is set; callers qualify
  // the result with their own "any request" term.
  function automatic logic [MAX_ID_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  valid,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  n_req
  );
    logic [MAX_ID_W-1:0] win;
    logic                found;
    logic [MAX_ID_W:0]   idx;
    win   = {MAX_ID_W{1'b0}};
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + (MAX_ID_W+1)'(k);
      if (idx >= (MAX_ID_W+1)'(n_req)) begin
        idx = idx - (MAX_ID_W+1)'(n_req);
      end else begin
        idx = idx;
      end
      if ((k < n_req) && !found && valid[idx[MAX_ID_W-1:0]]) begin
        win   = idx[MAX_ID_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/binary2gray.sv
// 4-bit combinational binary-to-Gray converter: gray = bin ^ (bin >> 1).
module binary2gray
  import gray_sched_pkg::*;
(
  input  logic [CODE_W-1:0] bin,
  output logic [CODE_W-1:0] gray
);

  assign gray = bin ^ {1'b0, bin[CODE_W-1:1]};

endmodule

// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler sharing one binary-to-Gray converter among N_REQ
// requesters. One-deep result register with valid/ready output and a
// saturating count of results taken downstream.
module gray_conv_scheduler
  import gray_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ),
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [CODE_W*N_REQ-1:0] req_bin,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CODE_W-1:0]       out_gray,
  output logic [CODE_W-1:0]       out_bin,
  output logic [ID_W-1:0]         out_id,
  output logic [CNT_W-1:0]        conv_cnt
);

  logic [ID_W-1:0]     rr_ptr_r;
  logic                valid_r;
  gray_result_t        result_r;
  logic [CNT_W-1:0]    cnt_r;

  logic [MAX_REQ-1:0]  valid_ext_s;
  logic [MAX_ID_W-1:0] ptr_ext_s;
  logic [MAX_ID_W-1:0] pick_s;
  logic [ID_W-1:0]     win_s;
  logic [ID_W-1:0]     ptr_next_s;
  logic                slot_free_s;
  logic                any_req_s;
  logic                accept_s;
  logic                drain_s;
  logic [CODE_W-1:0]   sel_bin_s;
  logic [CODE_W-1:0]   sel_gray_s;
  gray_result_t        next_s;
  logic                unused_pick_s;
  logic                unused_id_s;

  // Widen request vector and pointer to the package search width.
  always_comb begin
    valid_ext_s                 = {MAX_REQ{1'b0}};
    valid_ext_s[N_REQ-1:0]      = req_valid;
    ptr_ext_s                   = {MAX_ID_W{1'b0}};
    ptr_ext_s[ID_W-1:0]         = rr_ptr_r;
  end

  assign pick_s        = rr_pick(valid_ext_s, ptr_ext_s, N_REQ);
  assign win_s         = pick_s[ID_W-1:0];
  assign unused_pick_s = ^pick_s;

  // Handshake qualifiers: the slot frees when empty or draining this cycle.
  always_comb begin
    slot_free_s = !valid_r || out_ready;
    any_req_s   = |req_valid;
    accept_s    = !rst && slot_free_s && any_req_s;
    drain_s     = valid_r && out_ready;
  end

  // One-hot grant to the round-robin winner, only when it can be accepted.
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept_s && (win_s == ID_W'(i));
    end
  end

  // Route the winner's code to the shared converter.
  always_comb begin
    sel_bin_s = {CODE_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      sel_bin_s = (win_s == ID_W'(i)) ? req_bin[CODE_W*i +: CODE_W] : sel_bin_s;
    end
  end

  binary2gray u_binary2gray (
    .bin  (sel_bin_s),
    .gray (sel_gray_s)
  );

  // Assemble the result record and the pointer following the winner.
  always_comb begin
    next_s.bin  = sel_bin_s;
    next_s.gray = sel_gray_s;
    next_s.id   = {MAX_ID_W{1'b0}};
    next_s.id[ID_W-1:0] = win_s;
    if (win_s == ID_W'(N_REQ-1)) begin
      ptr_next_s = {ID_W{1'b0}};
    end else begin
      ptr_next_s = win_s + ID_W'(1);
    end
  end

  // Result register and round-robin pointer: load on accept, clear valid on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r       <= 1'b0;
      result_r.bin  <= {CODE_W{1'b0}};
      result_r.gray <= {CODE_W{1'b0}};
      result_r.id   <= {MAX_ID_W{1'b0}};
      rr_ptr_r      <= {ID_W{1'b0}};
    end else if (accept_s) begin
      valid_r  <= 1'b1;
      result_r <= next_s;
      rr_ptr_r <= ptr_next_s;
    end else if (drain_s) begin
      valid_r  <= 1'b0;
      result_r <= result_r;
      rr_ptr_r <= rr_ptr_r;
    end else begin
      valid_r  <= valid_r;
      result_r <= result_r;
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Saturating count of results taken downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (drain_s && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign unused_id_s = ^result_r.id;
  assign out_valid   = valid_r;
  assign out_gray    = result_r.gray;
  assign out_bin     = result_r.bin;
  assign out_id      = result_r.id[ID_W-1:0];
  assign conv_cnt    = cnt_r;

endmodule

// File: tb/tb_gray_conv_scheduler.sv
// Directed bench for gray_conv_scheduler with a behavioural model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_gray_conv_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [4*N-1:0] req_bin;
  logic          out_ready;

  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [3:0]    out_gray, out_bin;
  logic [1:0]    out_id;
  logic [15:0]   conv_cnt;

  logic [N-1:0]  sat_ready;
  logic          sat_valid;
  logic [3:0]    sat_gray, sat_bin;
  logic [1:0]    sat_id;
  logic [3:0]    sat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit         started = 1'b0;
  bit         m_valid;
  logic [3:0] m_bin, m_gray;
  int         m_id, m_ptr, m_cnt, m_cnt4;

  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  logic [3:0] rr_seq [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};

  gray_conv_scheduler #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_gray(out_gray), .out_bin(out_bin), .out_id(out_id), .conv_cnt(conv_cnt)
  );

  gray_conv_scheduler #(.N_REQ(4), .ID_W(2), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_bin(req_bin),
    .req_ready(sat_ready), .out_valid(sat_valid), .out_ready(out_ready),
    .out_gray(sat_gray), .out_bin(sat_bin), .out_id(sat_id), .conv_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bin(input int i, input logic [3:0] v);
    req_bin[4*i +: 4] = v;
  endtask

  // Expected grant: first valid requester at or after the pointer, if the slot is free.
  function automatic logic [3:0] model_ready();
    if (rst !== 1'b0) return 4'b0000;
    if (m_valid && !out_ready) return 4'b0000;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  // Model update at each rising edge from the inputs held across it.
  initial begin
    forever begin
      logic [3:0] g;
      bit         drain;
      int         w;
      logic [3:0] b;
      @(posedge clk);
      if (rst) begin
        m_valid = 1'b0; m_bin = 4'd0; m_gray = 4'd0; m_id = 0;
        m_ptr = 0; m_cnt = 0; m_cnt4 = 0;
      end else begin
        g     = model_ready();
        drain = m_valid && out_ready;
        if (drain) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt4 < 15) m_cnt4++;
        end
        if (g != 4'b0000) begin
          w = 0;
          for (int i = 0; i < N; i++) if (g[i]) w = i;
          b = req_bin[4*w +: 4];
          m_bin = b; m_gray = b ^ (b >> 1); m_id = w; m_valid = 1'b1;
          m_ptr = (w + 1) % N;
        end else if (drain) begin
          m_valid = 1'b0;
        end
      end
      started = 1'b1;
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("req_ready", req_ready, model_ready());
        chk("out_valid", out_valid, m_valid);
        chk("out_gray", out_gray, m_gray);
        chk("out_bin", out_bin, m_bin);
        chk("out_id", out_id, m_id[1:0]);
        chk("conv_cnt", conv_cnt, m_cnt[15:0]);
        chk("sat_cnt", sat_cnt, m_cnt4[3:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_bin = '0; out_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_cnt", conv_cnt, 16'd0);
    chk("rst_ready", req_ready, 4'b0000);

    // single requester
    tick();
    rst = 1'b0; req_valid = 4'b0010; set_bin(1, 4'd10);
    @(negedge clk);
    chk("single_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    chk("single_valid", out_valid, 1'b1);
    chk("single_gray", out_gray, 4'b1111);
    chk("single_bin", out_bin, 4'd10);
    chk("single_id", out_id, 2'd1);
    tick();
    @(negedge clk);
    chk("single_cnt", conv_cnt, 16'd1);

    // all requesters continuously valid, pointer starts at 2
    tick();
    req_valid = 4'b1111;
    set_bin(0, 4'd3); set_bin(1, 4'd4); set_bin(2, 4'd5); set_bin(3, 4'd6);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_order", req_ready, rr_seq[i % 4]);
      tick();
    end

    // backpressure with code 15 pending
    req_valid = 4'b0001; set_bin(0, 4'd15);
    @(negedge clk);
    chk("bp_grant", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1010; set_bin(1, 4'd5); set_bin(3, 4'd9); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_gray", out_gray, 4'b1000);
      chk("bp_ready", req_ready, 4'b0000);
      chk("bp_cnt", conv_cnt, 16'd9);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b1000;
    @(negedge clk);
    chk("rel_id", out_id, 2'd1);
    chk("rel_gray", out_gray, 4'b0111);
    tick();
    req_valid = 4'b0000;

    // exhaustive codes through requester 2
    for (int b = 0; b < 16; b++) begin
      req_valid = 4'b0100; set_bin(2, 4'(b));
      tick();
      chk("ex_gray", out_gray, gray_tab[b]);
      chk("ex_id", out_id, 2'd2);
    end
    req_valid = 4'b0000;

    // reset during a stall
    req_valid = 4'b0001; set_bin(0, 4'd7); out_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("stall_ready", req_ready, 4'b0000);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid = 4'b0011; set_bin(1, 4'd2); out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_cnt", conv_cnt, 16'd0);
    chk("rst_mid_grant", req_ready, 4'b0001);
    tick();
    chk("post_rst_id", out_id, 2'd0);
    chk("post_rst_gray", out_gray, 4'b0100);
    chk("post_rst_bin", out_bin, 4'd7);

    // saturation of the narrow counter
    req_valid = 4'b1111;
    repeat (20) tick();
    chk("sat_cnt15", sat_cnt, 4'd15);
    repeat (3) tick();
    chk("sat_hold", sat_cnt, 4'd15);
    chk("cnt_run", conv_cnt, 16'd23);

    req_valid = 4'b0000;
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
